// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, access owner and the DM streak limit.
// No logic here; imported by the arbiter top and the grant picker.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam logic [1:0] STREAK_LIMIT = 2'd2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave is the arbiter's view, master the environment's.
// Requests are level-held until their completion pulse; no other backpressure exists.
interface mem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_fetch;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_valid, dm_rdata, dm_done,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_fetch, stall_mem
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_valid, dm_rdata, dm_done,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_fetch, stall_mem
    );

endinterface

// File: rtl/arb_pick.sv
// Combinational grant picker: DM wins contention unless it has already won STREAK_LIMIT times in a row.
// Zero latency; pure function of the current requests and streak.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       if_req,
    input  logic       dm_req,
    input  logic [1:0] dm_streak,
    output logic       grant_valid,
    output owner_t     grant_owner
);

    always_comb begin
        grant_valid = if_req | dm_req;
        grant_owner = OWN_IF;
        // The older instruction (DM) goes first, but fetch must not starve.
        if (dm_req && !(if_req && dm_streak >= STREAK_LIMIT)) begin
            grant_owner = OWN_DM;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and data requesters, one access in flight; grant->pulse is MEM_LAT+2 cycles.
// Requests wait (held high) while an access is in flight; throughput is one access per MEM_LAT+3 cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input logic          CLOCK_50,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    owner_t            owner;
    logic [1:0]        dm_streak;
    logic [2:0]        wait_cnt;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              grant_valid;
    owner_t            grant_owner;
    logic              grant;
    logic              last_wait;

    arb_pick u_pick (
        .if_req      (bus.if_req),
        .dm_req      (bus.dm_req),
        .dm_streak   (dm_streak),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign grant     = (state == IDLE) && grant_valid;
    assign last_wait = (state == WAIT) && (wait_cnt == 3'd0);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (wait_cnt == 3'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_en   = (state == ISSUE);
        bus.mem_we   = (state == ISSUE) && acc_we;
        bus.if_valid = (state == RESP) && (owner == OWN_IF);
        bus.dm_done  = (state == RESP) && (owner == OWN_DM);
    end

    // Access attributes are latched at grant so an early request drop cannot disturb the access.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            owner      <= OWN_IF;
            dm_streak  <= 2'd0;
            wait_cnt   <= 3'd0;
            acc_we     <= 1'b0;
            acc_addr   <= '0;
            acc_wdata  <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (grant) begin
                owner     <= grant_owner;
                acc_we    <= (grant_owner == OWN_DM) && bus.dm_we;
                acc_addr  <= (grant_owner == OWN_DM) ? bus.dm_addr : bus.if_addr;
                acc_wdata <= bus.dm_wdata;
                if (grant_owner == OWN_IF) begin
                    dm_streak <= 2'd0;
                end else if (bus.if_req && dm_streak != STREAK_LIMIT) begin
                    dm_streak <= dm_streak + 2'd1;
                end
            end
            if (state == ISSUE) begin
                wait_cnt <= WAIT_INIT;
            end else if (state == WAIT && wait_cnt != 3'd0) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
            if (last_wait) begin
                if (owner == OWN_IF) begin
                    if_rdata_q <= bus.mem_rdata;
                end else if (!acc_we) begin
                    dm_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_addr    = acc_addr;
    assign bus.mem_wdata   = acc_wdata;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.dm_rdata    = dm_rdata_q;
    assign bus.stall_fetch = bus.if_req & ~bus.if_valid;
    assign bus.stall_mem   = bus.dm_req & ~bus.dm_done;

endmodule
